keypad_scanner: RTL and testbench

//  Sequences the elevator call-button matrix: drives one column at a time, waits for the rows to settle, then samples the rows.

---
 rtl/keypad_scanner_pkg.sv | 25 ++
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_scanner_debounce.sv | 41 ++++
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared constants, types and helpers for the keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;
  localparam int KEY_W    = $clog2(NUM_KEYS);

  typedef logic [KEY_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } scan_state_t;

  // Lowest set bit wins, so key 0 has the highest delivery priority.
  function automatic key_code_t lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = key_code_t'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Press-event handshake between the scanner (master) and the request logic (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic      key_valid;
  key_code_t key_code;
  logic      key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Per-key debouncer: the stable level flips only after DEBOUNCE_SCANS consecutive
// disagreeing samples; rise_o pulses in the sample cycle that flips the level 0->1.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flip;

  assign flip     = sample_i && (raw_i != stable_q) && (cnt_q == CNT_LAST);
  assign stable_o = stable_q;
  assign rise_o   = flip && raw_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sample_i) begin
      if (raw_i == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= raw_i;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobed keypad scanner: row sync, per-key debounce, press-event queue
// and a single-entry valid/ready output register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_en,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  keypad_scanner_if.master    key
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(NUM_COLS - 1);

  scan_state_t         state_q;
  logic [COL_W-1:0]    col_idx_q;
  logic [COL_W-1:0]    col_idx_next;
  logic [SET_W-1:0]    settle_q;
  logic [NUM_COLS-1:0] col_q;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic [NUM_KEYS-1:0] key_rise, key_stable;
  logic [NUM_KEYS-1:0] pending_q, pending_d, pending_clr;
  logic                valid_q;
  key_code_t           code_q;
  key_code_t           next_code;
  logic                pending_any, load;
  logic                unused_stable;

  assign col_idx_next = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_idx_q <= '0;
      settle_q  <= '0;
      col_q     <= '0;
    end else if (!scan_en) begin
      state_q   <= IDLE;
      col_idx_q <= '0;
      settle_q  <= '0;
      col_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= DRIVE;
          col_idx_q <= '0;
          settle_q  <= '0;
          col_q     <= NUM_COLS'(1);
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) state_q <= SAMPLE;
          else                         settle_q <= settle_q + 1'b1;
        end
        SAMPLE: begin
          state_q   <= DRIVE;
          settle_q  <= '0;
          col_idx_q <= col_idx_next;
          col_q     <= NUM_COLS'(1) << col_idx_next;
        end
        default: begin
          state_q <= IDLE;
          col_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= '0;
      row_s2_q <= '0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i ((state_q == SAMPLE) && (col_idx_q == COL_W'(c))),
        .raw_i    (row_s2_q[r]),
        .stable_o (key_stable[c*NUM_ROWS+r]),
        .rise_o   (key_rise[c*NUM_ROWS+r])
      );
    end
  end

  // Debounced levels are not needed here; only press edges are queued.
  assign unused_stable = ^key_stable;

  always_comb begin
    next_code   = lowest_set(pending_q);
    pending_any = |pending_q;
    load        = !valid_q || key.key_ready;
    pending_clr = '0;
    if (load && pending_any) pending_clr[next_code] = 1'b1;
    // A press landing on the bit being handed out is kept, not lost.
    pending_d = (pending_q & ~pending_clr) | key_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        if (pending_any) begin
          valid_q <= 1'b1;
          code_q  <= next_code;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign col           = col_q;
  assign key.key_valid = valid_q;
  assign key.key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key matrix model closes rows from the driven columns.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN = NUM_COLS * 9;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                scan_en;
  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic [NUM_KEYS-1:0] key_down;
  int                  n_cmp = 0;
  int                  n_err = 0;

  keypad_scanner_if kif ();

  keypad_scanner dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scan_en (scan_en),
    .row     (row),
    .col     (col),
    .key     (kif)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = '0;
    for (int c = 0; c < NUM_COLS; c++)
      for (int r = 0; r < NUM_ROWS; r++)
        if (key_down[c*NUM_ROWS+r] && col[c]) row[r] = 1'b1;
  end

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (kif.key_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_col(input logic [NUM_COLS-1:0] want, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (col == want) begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_valid(input int cycles, output int cnt, output key_code_t last);
    cnt = 0; last = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (kif.key_valid) begin cnt++; last = kif.key_code; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b0; kif.key_ready = 1'b0; key_down = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (col !== 4'b0000 || kif.key_valid !== 1'b0 || kif.key_code !== 4'd0) begin
      n_err++;
      $display("FAIL reset: col=%b valid=%b code=%0d, want col=0000 valid=0 code=0", col, kif.key_valid, kif.key_code);
    end
  endtask

  task automatic test_scan_timing();
    logic [NUM_COLS-1:0] exp;
    scan_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= SCAN; i++) begin
      @(negedge clk);
      exp = 4'b0001 << ((i / 9) % 4);
      n_cmp++;
      if (col !== exp) begin
        n_err++;
        $display("FAIL scan_timing[%0d]: col=%b, want %b", i, col, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    int cnt; key_code_t last;
    kif.key_ready = 1'b1;
    key_down[9] = 1'b1;
    count_valid(5 * SCAN, cnt, last);
    n_cmp++;
    if (cnt != 1 || last !== 4'd9) begin
      n_err++;
      $display("FAIL clean_press: pulses=%0d code=%0d, want pulses=1 code=9", cnt, last);
    end
    key_down[9] = 1'b0;
    count_valid(5 * SCAN, cnt, last);
    n_cmp++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL clean_release: pulses=%0d, want 0", cnt);
    end
  endtask

  task automatic test_bounce();
    int cnt, total; key_code_t last;
    total = 0;
    kif.key_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      key_down[9] = (s % 2 == 0);
      count_valid(SCAN, cnt, last);
      total += cnt;
    end
    key_down[9] = 1'b0;
    count_valid(2 * SCAN, cnt, last);
    total += cnt;
    n_cmp++;
    if (total != 0) begin
      n_err++;
      $display("FAIL bounce: valid cycles=%0d, want 0", total);
    end
  endtask

  task automatic test_two_keys();
    bit ok, stable; int cnt; key_code_t last;
    kif.key_ready = 1'b0;
    key_down[4] = 1'b1; key_down[6] = 1'b1;
    wait_valid(6 * SCAN, ok);
    n_cmp++;
    if (!ok || kif.key_code !== 4'd4) begin
      n_err++;
      $display("FAIL two_keys_first: valid=%b code=%0d, want valid=1 code=4", ok, kif.key_code);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd4) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_err++;
      $display("FAIL two_keys_hold: code moved while stalled, now valid=%b code=%0d, want 1/4", kif.key_valid, kif.key_code);
    end
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    n_cmp++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd6) begin
      n_err++;
      $display("FAIL two_keys_second: valid=%b code=%0d, want valid=1 code=6", kif.key_valid, kif.key_code);
    end
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    n_cmp++;
    if (kif.key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL two_keys_drain: valid=%b, want 0", kif.key_valid);
    end
    key_down[4] = 1'b0; key_down[6] = 1'b0;
    count_valid(5 * SCAN, cnt, last);
    n_cmp++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL two_keys_release: valid cycles=%0d, want 0", cnt);
    end
  endtask

  task automatic test_park();
    bit ok; int cnt; key_code_t last;
    kif.key_ready = 1'b0;
    key_down[8] = 1'b1; key_down[9] = 1'b1;
    wait_valid(6 * SCAN, ok);
    n_cmp++;
    if (!ok || kif.key_code !== 4'd8) begin
      n_err++;
      $display("FAIL park_first: valid=%b code=%0d, want valid=1 code=8", ok, kif.key_code);
    end
    wait_col(4'b0100, 2 * SCAN, ok);
    scan_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!ok || col !== 4'b0000) begin
      n_err++;
      $display("FAIL park_col: reached=%b col=%b, want reached=1 col=0000", ok, col);
    end
    repeat (5) @(negedge clk);
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    n_cmp++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd9 || col !== 4'b0000) begin
      n_err++;
      $display("FAIL park_deliver: valid=%b code=%0d col=%b, want 1/9/0000", kif.key_valid, kif.key_code, col);
    end
    kif.key_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (kif.key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL park_drain: valid=%b, want 0", kif.key_valid);
    end
    scan_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (col !== 4'b0001) begin
      n_err++;
      $display("FAIL park_resume: col=%b, want 0001", col);
    end
    key_down[8] = 1'b0; key_down[9] = 1'b0;
    count_valid(5 * SCAN, cnt, last);
    n_cmp++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL park_release: valid cycles=%0d, want 0", cnt);
    end
  endtask

  task automatic test_async_reset();
    bit ok, okc; int cnt; key_code_t last;
    kif.key_ready = 1'b0;
    key_down[0] = 1'b1;
    wait_valid(6 * SCAN, ok);
    key_down[0] = 1'b0;
    wait_col(4'b1000, 2 * SCAN, okc);
    n_cmp++;
    if (!ok || !okc || kif.key_code !== 4'd0 || kif.key_valid !== 1'b1) begin
      n_err++;
      $display("FAIL areset_setup: valid_seen=%b col_seen=%b valid=%b code=%0d, want 1/1/1/0", ok, okc, kif.key_valid, kif.key_code);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (kif.key_valid !== 1'b0 || col !== 4'b0000 || kif.key_code !== 4'd0) begin
      n_err++;
      $display("FAIL areset_immediate: valid=%b col=%b code=%0d, want 0/0000/0", kif.key_valid, col, kif.key_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    kif.key_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (col !== 4'b0001) begin
      n_err++;
      $display("FAIL areset_restart: col=%b, want 0001", col);
    end
    count_valid(5 * SCAN, cnt, last);
    n_cmp++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL areset_stale: valid cycles=%0d, want 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_park();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
